id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register, directly downstream of decode-stage immediate extension and register-file read.
- Captures decoded control, RD1/RD2, register indices, PC, PC+4 and ImmExtD each cycle and presents them to the execute stage and the forwarding unit.
- Supports hold (stall), bubble insertion (flush) and a per-stage valid bit. This lets the hazard unit resolve load-use hazards and taken-branch squashes.

Parameters:
- XLEN, 32, datapath width of RD1/RD2/PC/PC+4/ImmExt.
- REG_AW, 5, register index width.
- ALUC_W, 3, ALUControl width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- EnE  input  1  load enable; 0 = hold current contents (stall)
- FlushE  input  1  insert bubble on next edge
- ValidD  input  1  decode-stage instruction is valid
- RegWriteD  input  1  control: register write
- ResultSrcD  input  2  control: result mux select
- MemWriteD  input  1  control: memory write
- JumpD  input  1  control: jump
- BranchD  input  1  control: branch
- ALUControlD  input  ALUC_W  control: ALU op
- ALUSrcD  input  1  control: ALU B select (1 = immediate)
- RD1D  input  XLEN  register operand 1
- RD2D  input  XLEN  register operand 2
- PCD  input  XLEN  instruction PC
- PCPlus4D  input  XLEN  PC+4
- ImmExtD  input  XLEN  sign-extended immediate (I/S format)
- Rs1D, Rs2D, RdD  input  REG_AW  source/destination indices
- ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE  output  same widths as D counterparts  registered execute-stage copies

Behaviour:
- All outputs registered; 1-cycle latency D to E. No combinational path input to output.
- reset asserted (async, any time including mid-stall): every output goes to 0 immediately and stays 0 until the first rising edge after deassertion.
- Priority at each rising edge: reset > FlushE > EnE==0 > load.
- FlushE=1 (regardless of EnE): load a bubble.
  - Bubble = ValidE, RegWriteE, MemWriteE, JumpE, BranchE all 0.
  - All remaining outputs (data, indices, ResultSrcE, ALUControlE, ALUSrcE) are also 0, so RdE=0 and forwarding never matches a bubble.
- FlushE=0, EnE=0: all outputs hold their previous values.
- FlushE=0, EnE=1, ValidD=1: every E output takes its D input; ValidE=1.
- FlushE=0, EnE=1, ValidD=0: load a bubble (identical to flush). Garbage decode never reaches execute with side-effecting controls set.
- Back-to-back flushes: each edge reloads a bubble. No state beyond the registers, no FSM; stage state is {Valid, Bubble} = ValidE.
- Widths pass through unchanged. No arithmetic in the base block.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: adds output port BubbleCntE (32-bit).
  - Reset to 0.
  - Increments by 1 on each edge where a bubble is loaded (FlushE=1, or EnE=1 with ValidD=0).
  - Does not increment while holding.
  - Saturates at 32'hFFFF_FFFF (no wrap).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-operation: load RdD=5, RegWriteD=1, ValidD=1, EnE=1, one edge, then pulse reset between edges -> all outputs 0 immediately (async), ValidE=0, RdE=0.
- Normal load: ImmExtD=32'hFFFF_F800, RD1D=32'h0000_0010, RdD=7, ALUSrcD=1, ValidD=1, EnE=1 -> after one edge ImmExtE=32'hFFFF_F800, RD1E=32'h10, RdE=7, ALUSrcE=1, ValidE=1.
- Stall: after a load, drive EnE=0 with new inputs (RdD=9, ImmExtD=0) for 3 edges -> RdE stays 7 and ImmExtE stays 32'hFFFF_F800 throughout; then EnE=1 -> RdE=9 next edge.
- Flush overrides stall: FlushE=1, EnE=0, inputs MemWriteD=1, RdD=3 -> next edge MemWriteE=0, RdE=0, ValidE=0, all data outputs 0.
- Invalid decode: EnE=1, FlushE=0, ValidD=0, RegWriteD=1, RdD=4 -> RegWriteE=0, RdE=0, ValidE=0.
- With IDEX_PERF_CNT_EN: 2 flush edges, 1 ValidD=0 edge, 2 hold edges, 1 valid load -> BubbleCntE=3. Preload near saturation -> counter sticks at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
//
// The ID/EX pipeline register. It sits directly after decode-stage immediate
// extension and register-file read. Each cycle it captures the decoded control
// fields, both operands, the register indices, PC, PC+4 and the extended
// immediate, and presents them to the execute stage and the forwarding unit.
//
// The hazard unit controls it through two inputs:
//   - EnE = 0 holds the stage, to stall on a load-use hazard.
//   - FlushE = 1 squashes the stage into a bubble, for a taken branch.
//
// A bubble is an all-zero stage. ValidE and the side-effecting controls are 0,
// and RdE = 0, so forwarding can never match a squashed instruction.
//
// Priority at each rising edge: reset > FlushE > hold (EnE=0) > load.
// A load with ValidD = 0 also produces a bubble.
//
// Ports
//   clk, reset               rising-edge clock; asynchronous active-high reset
//   EnE, FlushE              stage enable (0 = hold), bubble insertion
//   ValidD + *D              decode-stage valid bit, control, data and indices
//   ValidE + *E              registered execute-stage copies (1-cycle latency)
//   BubbleCntE               (IDEX_PERF_CNT_EN only) saturating count of
//                            edges that loaded a bubble
//
// Optional feature: define IDEX_PERF_CNT_EN to add the BubbleCntE counter.
// -----------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              EnE,
    input  logic              FlushE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              ALUSrcD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              ALUSrcE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       BubbleCntE
`endif
);

    // One packed record for the whole stage. Loading a bubble is then a
    // single '0 assignment, so no field can be missed.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic [ALUC_W-1:0] alu_control;
        logic              alu_src;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   imm_ext;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } stage_t;

    stage_t stage_d;
    stage_t stage_q;

    // Invalid decode is squashed exactly like a flush. Garbage control bits
    // therefore never reach execute.
    logic bubble_load;
    assign bubble_load = FlushE | (EnE & ~ValidD);

    always_comb begin
        // NOTE: default to the current contents first. Every path then assigns
        // stage_d, the hold case is explicit, and no latch is inferred.
        stage_d = stage_q;
        if (bubble_load) begin
            stage_d = '0;
        end else if (EnE) begin
            stage_d.valid       = 1'b1;
            stage_d.reg_write   = RegWriteD;
            stage_d.result_src  = ResultSrcD;
            stage_d.mem_write   = MemWriteD;
            stage_d.jump        = JumpD;
            stage_d.branch      = BranchD;
            stage_d.alu_control = ALUControlD;
            stage_d.alu_src     = ALUSrcD;
            stage_d.rd1         = RD1D;
            stage_d.rd2         = RD2D;
            stage_d.pc          = PCD;
            stage_d.pc_plus4    = PCPlus4D;
            stage_d.imm_ext     = ImmExtD;
            stage_d.rs1         = Rs1D;
            stage_d.rs2         = Rs2D;
            stage_d.rd          = RdD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. This keeps
    // every register sampling its pre-edge inputs, whatever the evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ValidE      = stage_q.valid;
    assign RegWriteE   = stage_q.reg_write;
    assign ResultSrcE  = stage_q.result_src;
    assign MemWriteE   = stage_q.mem_write;
    assign JumpE       = stage_q.jump;
    assign BranchE     = stage_q.branch;
    assign ALUControlE = stage_q.alu_control;
    assign ALUSrcE     = stage_q.alu_src;
    assign RD1E        = stage_q.rd1;
    assign RD2E        = stage_q.rd2;
    assign PCE         = stage_q.pc;
    assign PCPlus4E    = stage_q.pc_plus4;
    assign ImmExtE     = stage_q.imm_ext;
    assign Rs1E        = stage_q.rs1;
    assign Rs2E        = stage_q.rs2;
    assign RdE         = stage_q.rd;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_d;
    logic [31:0] bubble_cnt_q;

    // The counter saturates instead of wrapping, so a long-running count
    // never reads back as a small value.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
`endif

endmodule
